// File: rtl/uc_multicycle_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control unit.
package uc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EX_R     = 4'd2,
    EX_I     = 4'd3,
    AUIPC    = 4'd4,
    WB_ALU   = 4'd5,
    LUI      = 4'd6,
    MEM_ADDR = 4'd7,
    MEM_RD   = 4'd8,
    WB_MEM   = 4'd9,
    MEM_WR   = 4'd10,
    BRANCH   = 4'd11,
    JAL      = 4'd12,
    JALR     = 4'd13,
    ILLEGAL  = 4'd14,
    HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RF_MEM = 2'b00;
  localparam logic [1:0] RF_ALU = 2'b01;
  localparam logic [1:0] RF_PC4 = 2'b10;
  localparam logic [1:0] RF_IMM = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_FUNCT = 2'b01;
  localparam logic [1:0] ALU_CMP   = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/uc_multicycle_if.sv
// Memory request/ready handshake between the control unit and the memory port.
interface uc_multicycle_if;
  logic mem_req;
  logic mem_ready;
  logic WE_MEM;
  logic addr_sel;

  modport master (output mem_req, output WE_MEM, output addr_sel, input mem_ready);
  modport slave  (input mem_req, input WE_MEM, input addr_sel, output mem_ready);
endinterface

// File: rtl/uc_multicycle_mem_wait.sv
// Memory wait counter; expired fires on the last allowed waiting cycle (never when MEM_TIMEOUT is 0).
module uc_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'((MEM_TIMEOUT == 0) ? 32'd0 : MEM_TIMEOUT - 32'd1);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (clear)          cnt <= '0;
    else if (req && !ready)  cnt <= cnt + TMO_W'(1);
  end

  // Firing on the count of already-elapsed waits gives exactly MEM_TIMEOUT waiting cycles.
  assign expired = (MEM_TIMEOUT != 0) && req && !ready && (cnt == LAST);

endmodule

// File: rtl/uc_multicycle.sv
// Multi-cycle RV32I control FSM with memory handshake timeout.
// Define UC_ILLEGAL_TRAP_EN to halt on illegal opcodes and expose illegal_op.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMO_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uc_multicycle_if.master        mem,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   branch_taken,
  output logic                   WE_RF,
  output logic [1:0]             RF_din_sel,
  output logic                   ULA_din1_sel,
  output logic                   ULA_din2_sel,
  output logic [1:0]             alu_op,
  output logic                   load_ir,
  output logic                   load_pc,
  output logic                   pc_next_sel,
  output logic                   pc_adder_sel,
  output logic                   mem_err
`ifdef UC_ILLEGAL_TRAP_EN
  ,
  output logic                   illegal_op
`endif
);

  state_t state, next;
  logic   req_int, we_mem_int, expired, clear;
  logic   funct3_unused;

  assign funct3_unused = ^funct3;

  assign req_int = is_mem_state(state);
  assign clear   = is_mem_state(next) && (next != state);

  uc_mem_wait #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMO_W       (TMO_W)
  ) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_int),
    .ready   (mem.mem_ready),
    .clear   (clear),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      mem_err <= 1'b0;
    end else begin
      state <= next;
      if (expired) mem_err <= 1'b1;
    end
  end

  always_comb begin
    next         = state;
    we_mem_int   = 1'b0;
    mem.addr_sel = 1'b0;
    WE_RF        = 1'b0;
    RF_din_sel   = RF_MEM;
    ULA_din1_sel = 1'b0;
    ULA_din2_sel = 1'b0;
    alu_op       = ALU_ADD;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    pc_next_sel  = 1'b0;
    pc_adder_sel = 1'b0;
    case (state)
      FETCH: begin
        mem.addr_sel = 1'b1;
        if (expired)            next = HALT;
        else if (mem.mem_ready) begin
          load_ir = 1'b1;
          next    = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R:               next = EX_R;
          OP_I:               next = EX_I;
          OP_LOAD, OP_STORE:  next = MEM_ADDR;
          OP_BRANCH:          next = BRANCH;
          OP_JAL:             next = JAL;
          OP_JALR:            next = JALR;
          OP_LUI:             next = LUI;
          OP_AUIPC:           next = AUIPC;
          default:            next = ILLEGAL;
        endcase
      end
      EX_R: begin
        alu_op = ALU_FUNCT;
        next   = WB_ALU;
      end
      EX_I: begin
        alu_op       = ALU_FUNCT;
        ULA_din2_sel = 1'b1;
        next         = WB_ALU;
      end
      AUIPC: begin
        ULA_din1_sel = 1'b1;
        ULA_din2_sel = 1'b1;
        next         = WB_ALU;
      end
      WB_ALU: begin
        // IR is stable until the next fetch, so the opcode recovers which ALU setup to hold.
        WE_RF        = 1'b1;
        RF_din_sel   = RF_ALU;
        load_pc      = 1'b1;
        ULA_din1_sel = (opcode == OP_AUIPC);
        ULA_din2_sel = (opcode != OP_R);
        alu_op       = (opcode == OP_AUIPC) ? ALU_ADD : ALU_FUNCT;
        next         = FETCH;
      end
      LUI: begin
        WE_RF      = 1'b1;
        RF_din_sel = RF_IMM;
        load_pc    = 1'b1;
        next       = FETCH;
      end
      MEM_ADDR: begin
        ULA_din2_sel = 1'b1;
        next         = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        if (expired)            next = HALT;
        else if (mem.mem_ready) next = WB_MEM;
      end
      WB_MEM: begin
        WE_RF      = 1'b1;
        RF_din_sel = RF_MEM;
        load_pc    = 1'b1;
        next       = FETCH;
      end
      MEM_WR: begin
        we_mem_int = 1'b1;
        if (expired) next = HALT;
        else if (mem.mem_ready) begin
          load_pc = 1'b1;
          next    = FETCH;
        end
      end
      BRANCH: begin
        alu_op       = ALU_CMP;
        load_pc      = 1'b1;
        pc_adder_sel = branch_taken;
        next         = FETCH;
      end
      JAL: begin
        WE_RF        = 1'b1;
        RF_din_sel   = RF_PC4;
        load_pc      = 1'b1;
        pc_adder_sel = 1'b1;
        next         = FETCH;
      end
      JALR: begin
        ULA_din2_sel = 1'b1;
        WE_RF        = 1'b1;
        RF_din_sel   = RF_PC4;
        load_pc      = 1'b1;
        pc_next_sel  = 1'b1;
        next         = FETCH;
      end
      ILLEGAL: begin
`ifdef UC_ILLEGAL_TRAP_EN
        next = HALT;
`else
        load_pc = 1'b1;
        next    = FETCH;
`endif
      end
      HALT:    next = HALT;
      default: next = FETCH;
    endcase
  end

  // Gated by reset_n so an access in flight is withdrawn the moment reset asserts.
  assign mem.mem_req = req_int & reset_n;
  assign mem.WE_MEM  = we_mem_int & reset_n;

`ifdef UC_ILLEGAL_TRAP_EN
  assign illegal_op = (state == HALT) && !mem_err;
`endif

endmodule

// File: tb/tb_uc_multicycle.sv
// Directed bench for uc_multicycle; control outputs compared as one packed vector per cycle.
module tb_uc_multicycle;

  logic       clk;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken;
  logic       WE_RF, ULA_din1_sel, ULA_din2_sel, load_ir, load_pc;
  logic       pc_next_sel, pc_adder_sel, mem_err;
  logic [1:0] RF_din_sel, alu_op;
`ifdef UC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif
  logic [14:0] ctl;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  uc_multicycle_if mif ();

  uc_multicycle #(
    .MEM_TIMEOUT (15),
    .TMO_W       (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem          (mif),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .WE_RF        (WE_RF),
    .RF_din_sel   (RF_din_sel),
    .ULA_din1_sel (ULA_din1_sel),
    .ULA_din2_sel (ULA_din2_sel),
    .alu_op       (alu_op),
    .load_ir      (load_ir),
    .load_pc      (load_pc),
    .pc_next_sel  (pc_next_sel),
    .pc_adder_sel (pc_adder_sel),
    .mem_err      (mem_err)
`ifdef UC_ILLEGAL_TRAP_EN
    ,
    .illegal_op   (illegal_op)
`endif
  );

  // {mem_req, WE_MEM, addr_sel, WE_RF, RF_din_sel, din1, din2, alu_op, load_ir, load_pc, pc_next_sel, pc_adder_sel, mem_err}
  assign ctl = {mif.mem_req, mif.WE_MEM, mif.addr_sel, WE_RF, RF_din_sel, ULA_din1_sel,
                ULA_din2_sel, alu_op, load_ir, load_pc, pc_next_sel, pc_adder_sel, mem_err};

  localparam logic [14:0] RST_V  = 15'b0_0_1_0_00_0_0_00_0_0_0_0_0;
  localparam logic [14:0] F_WAIT = 15'b1_0_1_0_00_0_0_00_0_0_0_0_0;
  localparam logic [14:0] F_RDY  = 15'b1_0_1_0_00_0_0_00_1_0_0_0_0;
  localparam logic [14:0] DEC    = 15'b0_0_0_0_00_0_0_00_0_0_0_0_0;
  localparam logic [14:0] EXR_V  = 15'b0_0_0_0_00_0_0_01_0_0_0_0_0;
  localparam logic [14:0] WBR_V  = 15'b0_0_0_1_01_0_0_01_0_1_0_0_0;
  localparam logic [14:0] EXI_V  = 15'b0_0_0_0_00_0_1_01_0_0_0_0_0;
  localparam logic [14:0] WBI_V  = 15'b0_0_0_1_01_0_1_01_0_1_0_0_0;
  localparam logic [14:0] EXA_V  = 15'b0_0_0_0_00_1_1_00_0_0_0_0_0;
  localparam logic [14:0] WBA_V  = 15'b0_0_0_1_01_1_1_00_0_1_0_0_0;
  localparam logic [14:0] LUI_V  = 15'b0_0_0_1_11_0_0_00_0_1_0_0_0;
  localparam logic [14:0] JAL_V  = 15'b0_0_0_1_10_0_0_00_0_1_0_1_0;
  localparam logic [14:0] JALR_V = 15'b0_0_0_1_10_0_1_00_0_1_1_0_0;
  localparam logic [14:0] MADDR  = 15'b0_0_0_0_00_0_1_00_0_0_0_0_0;
  localparam logic [14:0] MRD    = 15'b1_0_0_0_00_0_0_00_0_0_0_0_0;
  localparam logic [14:0] WBMEM  = 15'b0_0_0_1_00_0_0_00_0_1_0_0_0;
  localparam logic [14:0] MWR    = 15'b1_1_0_0_00_0_0_00_0_0_0_0_0;
  localparam logic [14:0] MWR_DN = 15'b1_1_0_0_00_0_0_00_0_1_0_0_0;
  localparam logic [14:0] BR_T   = 15'b0_0_0_0_00_0_0_10_0_1_0_1_0;
  localparam logic [14:0] BR_N   = 15'b0_0_0_0_00_0_0_10_0_1_0_0_0;
  localparam logic [14:0] NOP_V  = 15'b0_0_0_0_00_0_0_00_0_1_0_0_0;
  localparam logic [14:0] HALT_E = 15'b0_0_0_0_00_0_0_00_0_0_0_0_1;
  localparam logic [14:0] HALT_I = 15'b0_0_0_0_00_0_0_00_0_0_0_0_0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle, compare outputs, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic rdy, input logic bt, input logic [14:0] exp);
    mif.mem_ready = rdy;
    branch_taken  = bt;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n       = 1'b0;
    mif.mem_ready = 1'b0;
    #1;
    check({tag, "_in_reset"}, 32'(ctl), 32'(RST_V));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check({tag, "_released"}, 32'(ctl), 32'(F_WAIT));
  endtask

  initial begin
    reset_n       = 1'b0;
    mif.mem_ready = 1'b0;
    opcode        = 7'b0;
    funct3        = 3'b0;
    branch_taken  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", 32'(ctl), 32'(RST_V));
    reset_n = 1'b1;
    cyc("fetch_wait", 1'b0, 1'b0, F_WAIT);

    opcode = 7'b0010011;
    cyc("addi_fetch", 1'b1, 1'b0, F_RDY);
    cyc("addi_dec",   1'b1, 1'b0, DEC);
    cyc("addi_ex",    1'b1, 1'b0, EXI_V);
    cyc("addi_wb",    1'b1, 1'b0, WBI_V);
`ifdef UC_ILLEGAL_TRAP_EN
    check("illegal_op_idle", 32'(illegal_op), 32'(0));
`endif

    opcode = 7'b0110011;
    cyc("add_fetch", 1'b1, 1'b0, F_RDY);
    cyc("add_dec",   1'b0, 1'b0, DEC);
    cyc("add_ex",    1'b0, 1'b0, EXR_V);
    cyc("add_wb",    1'b0, 1'b0, WBR_V);

    opcode = 7'b0010111;
    cyc("auipc_fetch", 1'b1, 1'b0, F_RDY);
    cyc("auipc_dec",   1'b0, 1'b0, DEC);
    cyc("auipc_ex",    1'b0, 1'b0, EXA_V);
    cyc("auipc_wb",    1'b0, 1'b0, WBA_V);

    opcode = 7'b0110111;
    cyc("lui_fetch", 1'b1, 1'b0, F_RDY);
    cyc("lui_dec",   1'b0, 1'b0, DEC);
    cyc("lui_ex",    1'b0, 1'b0, LUI_V);

    opcode = 7'b1101111;
    cyc("jal_fetch", 1'b1, 1'b0, F_RDY);
    cyc("jal_dec",   1'b0, 1'b0, DEC);
    cyc("jal_ex",    1'b0, 1'b0, JAL_V);

    opcode = 7'b1100111;
    cyc("jalr_fetch", 1'b1, 1'b0, F_RDY);
    cyc("jalr_dec",   1'b0, 1'b0, DEC);
    cyc("jalr_ex",    1'b0, 1'b0, JALR_V);

    opcode = 7'b0000011;
    cyc("lw_fetch", 1'b1, 1'b0, F_RDY);
    cyc("lw_dec",   1'b0, 1'b0, DEC);
    cyc("lw_addr",  1'b1, 1'b0, MADDR);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 1'b0, 1'b0, MRD);
    cyc("lw_ready", 1'b1, 1'b0, MRD);
    cyc("lw_wb",    1'b0, 1'b0, WBMEM);

    opcode = 7'b1100011;
    cyc("beq_t_fetch", 1'b1, 1'b0, F_RDY);
    cyc("beq_t_dec",   1'b0, 1'b1, DEC);
    cyc("beq_taken",   1'b0, 1'b1, BR_T);
    cyc("beq_n_fetch", 1'b1, 1'b0, F_RDY);
    cyc("beq_n_dec",   1'b0, 1'b0, DEC);
    cyc("beq_not",     1'b0, 1'b0, BR_N);

    opcode = 7'b0100011;
    cyc("sw_fetch", 1'b1, 1'b0, F_RDY);
    cyc("sw_dec",   1'b0, 1'b0, DEC);
    cyc("sw_addr",  1'b0, 1'b0, MADDR);
    cyc("sw_wait",  1'b0, 1'b0, MWR);
    cyc("sw_done",  1'b1, 1'b0, MWR_DN);
    cyc("sw_next",  1'b0, 1'b0, F_WAIT);

    cyc("swr_fetch", 1'b1, 1'b0, F_RDY);
    cyc("swr_dec",   1'b0, 1'b0, DEC);
    cyc("swr_addr",  1'b0, 1'b0, MADDR);
    mif.mem_ready = 1'b0;
    #1;
    check("swr_in_mem_wr", 32'(ctl), 32'(MWR));
    do_reset("swr_reset");

    opcode = 7'b0000000;
    cyc("ill_fetch", 1'b1, 1'b0, F_RDY);
    cyc("ill_dec",   1'b0, 1'b0, DEC);
`ifdef UC_ILLEGAL_TRAP_EN
    cyc("ill_state", 1'b0, 1'b0, HALT_I);
    check("ill_halt_flag", 32'(illegal_op), 32'(1));
    cyc("ill_halt", 1'b1, 1'b0, HALT_I);
    cyc("ill_halt_hold", 1'b1, 1'b0, HALT_I);
    do_reset("ill_reset");
`else
    cyc("ill_nop",   1'b0, 1'b0, NOP_V);
    cyc("ill_after", 1'b0, 1'b0, F_WAIT);
`endif

    opcode = 7'b0100011;
    cyc("tmo_fetch", 1'b1, 1'b0, F_RDY);
    cyc("tmo_dec",   1'b0, 1'b0, DEC);
    cyc("tmo_addr",  1'b0, 1'b0, MADDR);
    for (int i = 0; i < 15; i++) cyc("tmo_wait", 1'b0, 1'b0, MWR);
`ifdef UC_ILLEGAL_TRAP_EN
    #1;
    check("tmo_not_illegal", 32'(illegal_op), 32'(0));
`endif
    cyc("tmo_halt",      1'b1, 1'b0, HALT_E);
    cyc("tmo_halt_hold", 1'b1, 1'b0, HALT_E);
    cyc("tmo_halt_late", 1'b0, 1'b0, HALT_E);
    do_reset("tmo_reset");
    check("tmo_err_cleared", 32'(mem_err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
